// File: rtl/inst_buffer_pkg.sv
// Shared fetch/decode types and default sizes for the instruction buffer.
package inst_buffer_pkg;

   localparam int FETCH_WIDTH  = 1;
   localparam int DECODE_WIDTH = 2;
   localparam int IB_DEPTH     = 16;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fb_entry_t;

endpackage

// File: rtl/inst_buffer_mem.sv
// Circular register array for inst_buffer: FETCH_WIDTH write ports at
// consecutive addresses, OUT_WIDTH combinational read ports at consecutive
// addresses. Addresses wrap modulo DEPTH. Contents are not reset.
module inst_buffer_mem
   import inst_buffer_pkg::*;
#(
   parameter int DEPTH     = IB_DEPTH,
   parameter int WR_PORTS  = FETCH_WIDTH,
   parameter int RD_PORTS  = DECODE_WIDTH
) (
   input  logic                            clock,
   input  logic                            wr_en_i,
   input  logic [$clog2(DEPTH)-1:0]        wr_addr_i,
   input  fb_entry_t [WR_PORTS-1:0]        wr_data_i,
   input  logic [$clog2(DEPTH)-1:0]        rd_addr_i,
   output fb_entry_t [RD_PORTS-1:0]        rd_data_o
);
   localparam int AW = $clog2(DEPTH);

   fb_entry_t mem_q [DEPTH];

   // Write the whole fetch group starting at the tail slot.
   always_ff @(posedge clock) begin
      if (wr_en_i) begin
         for (int w = 0; w < WR_PORTS; w++) begin
            mem_q[wr_addr_i + AW'(w)] <= wr_data_i[w];
         end
      end
   end

   // Present the oldest entries starting at the head slot.
   always_comb begin
      rd_data_o = '0;
      for (int r = 0; r < RD_PORTS; r++) begin
         rd_data_o[r] = mem_q[rd_addr_i + AW'(r)];
      end
   end

endmodule

// File: rtl/inst_buffer.sv
// Decoupling FIFO between instruction fetch and decode. Accepts one fetch
// group per cycle, presents up to OUT_WIDTH oldest entries in program order,
// back-pressures fetch through stall, and empties on flush.
// Optional build macro: INST_BUFFER_PERF_EN adds saturating stall-cycle and
// flush-count performance counters.
module inst_buffer
   import inst_buffer_pkg::*;
#(
   parameter int DEPTH     = IB_DEPTH,
   parameter int OUT_WIDTH = DECODE_WIDTH
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          flush,
   input  fb_entry_t [FETCH_WIDTH-1:0]   insts_in,
   input  logic                          insts_in_valid,
   output logic                          stall,
   output fb_entry_t [OUT_WIDTH-1:0]     insts_out,
   output logic [OUT_WIDTH-1:0]          insts_out_valid,
   input  logic                          insts_out_ready
`ifdef INST_BUFFER_PERF_EN
   ,
   output logic [31:0]                   perf_stall_cycles,
   output logic [31:0]                   perf_flush_count
`endif
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] pop_n;
   logic          push;

   // Stall depends on registered count only, so fetch sees no input loop.
   assign stall = (CW'(DEPTH) - count_q) < CW'(FETCH_WIDTH);
   assign push  = insts_in_valid & ~stall & ~flush;

   // Per-slot valid is contiguous from slot 0 and masked during a redirect.
   always_comb begin
      insts_out_valid = '0;
      for (int i = 0; i < OUT_WIDTH; i++) begin
         insts_out_valid[i] = (CW'(i) < count_q) & ~flush;
      end
   end

   // Pointer and occupancy update; flush wins over any push or pop.
   always_comb begin
      pop_n   = '0;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (insts_out_ready && !flush) begin
         pop_n = (count_q < CW'(OUT_WIDTH)) ? count_q : CW'(OUT_WIDTH);
      end
      head_d  = head_q + PW'(pop_n);
      if (push) begin
         tail_d = tail_q + PW'(FETCH_WIDTH);
      end
      count_d = count_q + (push ? CW'(FETCH_WIDTH) : '0) - pop_n;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   // Pointer and count registers; reset has priority over flush.
   always_ff @(posedge clock) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   inst_buffer_mem #(
      .DEPTH    (DEPTH),
      .WR_PORTS (FETCH_WIDTH),
      .RD_PORTS (OUT_WIDTH)
   ) u_mem (
      .clock     (clock),
      .wr_en_i   (push),
      .wr_addr_i (tail_q),
      .wr_data_i (insts_in),
      .rd_addr_i (head_q),
      .rd_data_o (insts_out)
   );

`ifdef INST_BUFFER_PERF_EN
   logic [31:0] perf_stall_q;
   logic [31:0] perf_flush_q;

   // Saturating event counters; flush does not clear them.
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         if (stall && (perf_stall_q != '1)) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
         if (flush && (perf_flush_q != '1)) begin
            perf_flush_q <= perf_flush_q + 32'd1;
         end
      end
   end

   assign perf_stall_cycles = perf_stall_q;
   assign perf_flush_count  = perf_flush_q;
`else
   // Counters are not built.
`endif

endmodule

// File: tb/tb_inst_buffer.sv
// Directed self-checking bench for inst_buffer with DEPTH=4, OUT_WIDTH=2.
module tb_inst_buffer;
   import inst_buffer_pkg::*;

   localparam int DEPTH = 4;
   localparam int OUTW  = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic flush = 1'b0;
   logic insts_in_valid = 1'b0;
   logic insts_out_ready = 1'b0;
   fb_entry_t [FETCH_WIDTH-1:0] insts_in = '0;
   logic stall;
   fb_entry_t [OUTW-1:0] insts_out;
   logic [OUTW-1:0] insts_out_valid;
`ifdef INST_BUFFER_PERF_EN
   logic [31:0] perf_stall_cycles;
   logic [31:0] perf_flush_count;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   inst_buffer #(.DEPTH(DEPTH), .OUT_WIDTH(OUTW)) dut (
      .clock           (clock),
      .reset           (reset),
      .flush           (flush),
      .insts_in        (insts_in),
      .insts_in_valid  (insts_in_valid),
      .stall           (stall),
      .insts_out       (insts_out),
      .insts_out_valid (insts_out_valid),
      .insts_out_ready (insts_out_ready)
`ifdef INST_BUFFER_PERF_EN
      ,
      .perf_stall_cycles (perf_stall_cycles),
      .perf_flush_count  (perf_flush_count)
`endif
   );

   function automatic fb_entry_t mk(input logic [31:0] pc, input logic [31:0] inst);
      fb_entry_t e;
      e.pc   = pc;
      e.inst = inst;
      return e;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; insts_in_valid = 1'b0; insts_out_ready = 1'b0;
      step(); step();
      reset = 1'b0;
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall); end
      total++; if (insts_out_valid !== 2'b00) begin bad++; $display("FAIL rst_valid got=%b exp=00", insts_out_valid); end
`ifdef INST_BUFFER_PERF_EN
      total++; if (perf_stall_cycles !== 32'd0) begin bad++; $display("FAIL rst_perf_stall got=%0d exp=0", perf_stall_cycles); end
      total++; if (perf_flush_count !== 32'd0) begin bad++; $display("FAIL rst_perf_flush got=%0d exp=0", perf_flush_count); end
`endif
   endtask

   task automatic test_push_pop();
      insts_out_ready = 1'b0;
      insts_in_valid = 1'b1;
      insts_in[0] = mk(32'h0, 32'h0000_0013);
      step();
      total++; if (insts_out_valid !== 2'b01) begin bad++; $display("FAIL pp_valid1 got=%b exp=01", insts_out_valid); end
      insts_in[0] = mk(32'h4, 32'h0010_0093);
      step();
      insts_in_valid = 1'b0;
      #1;
      total++; if (insts_out_valid !== 2'b11) begin bad++; $display("FAIL pp_valid2 got=%b exp=11", insts_out_valid); end
      total++; if (insts_out[0].pc !== 32'h0) begin bad++; $display("FAIL pp_pc0 got=%h exp=0", insts_out[0].pc); end
      total++; if (insts_out[1].pc !== 32'h4) begin bad++; $display("FAIL pp_pc1 got=%h exp=4", insts_out[1].pc); end
      total++; if (insts_out[0].inst !== 32'h0000_0013) begin bad++; $display("FAIL pp_inst0 got=%h exp=00000013", insts_out[0].inst); end
      total++; if (insts_out[1].inst !== 32'h0010_0093) begin bad++; $display("FAIL pp_inst1 got=%h exp=00100093", insts_out[1].inst); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL pp_stall got=%b exp=0", stall); end
      insts_out_ready = 1'b1;
      step();
      insts_out_ready = 1'b0;
      #1;
      total++; if (insts_out_valid !== 2'b00) begin bad++; $display("FAIL pp_popped got=%b exp=00", insts_out_valid); end
   endtask

   task automatic test_full();
      insts_out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         insts_in_valid = 1'b1;
         insts_in[0] = mk(32'(4 * k), 32'h1000 + 32'(k));
         #1;
         if (k == 3) begin
            total++; if (stall !== 1'b0) begin bad++; $display("FAIL full_stall_pre got=%b exp=0", stall); end
         end
         step();
      end
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL full_stall got=%b exp=1", stall); end
      insts_in[0] = mk(32'h10, 32'h2000);
      step();
      insts_in_valid = 1'b0;
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL full_stall_hold got=%b exp=1", stall); end
      total++; if (insts_out[0].pc !== 32'h0) begin bad++; $display("FAIL full_head_kept got=%h exp=0", insts_out[0].pc); end
      insts_out_ready = 1'b1;
      step();
      insts_out_ready = 1'b0;
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL full_stall_drop got=%b exp=0", stall); end
      total++; if (insts_out_valid !== 2'b11) begin bad++; $display("FAIL full_valid got=%b exp=11", insts_out_valid); end
      total++; if (insts_out[0].pc !== 32'h8) begin bad++; $display("FAIL full_head got=%h exp=8", insts_out[0].pc); end
      total++; if (insts_out[1].pc !== 32'hC) begin bad++; $display("FAIL full_slot1 got=%h exp=c", insts_out[1].pc); end
      insts_out_ready = 1'b1;
      step();
      insts_out_ready = 1'b0;
      #1;
      total++; if (insts_out_valid !== 2'b00) begin bad++; $display("FAIL full_drain got=%b exp=00", insts_out_valid); end
   endtask

   task automatic test_flush();
      insts_out_ready = 1'b0;
      insts_in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         insts_in[0] = mk(32'h40 + 32'(4 * k), 32'h3000 + 32'(k));
         step();
      end
      insts_in_valid = 1'b0;
      #1;
      total++; if (insts_out_valid !== 2'b11) begin bad++; $display("FAIL fl_pre_valid got=%b exp=11", insts_out_valid); end
      flush = 1'b1;
      insts_in_valid = 1'b1;
      insts_in[0] = mk(32'h4C, 32'h3003);
      insts_out_ready = 1'b1;
      #1;
      total++; if (insts_out_valid !== 2'b00) begin bad++; $display("FAIL fl_during got=%b exp=00", insts_out_valid); end
      step();
      flush = 1'b0;
      insts_in_valid = 1'b0;
      insts_out_ready = 1'b0;
      #1;
      total++; if (insts_out_valid !== 2'b00) begin bad++; $display("FAIL fl_after got=%b exp=00", insts_out_valid); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL fl_stall got=%b exp=0", stall); end
`ifdef INST_BUFFER_PERF_EN
      total++; if (perf_flush_count !== 32'd1) begin bad++; $display("FAIL fl_perf got=%0d exp=1", perf_flush_count); end
`endif
      insts_in_valid = 1'b1;
      insts_in[0] = mk(32'h50, 32'h3010);
      step();
      insts_in_valid = 1'b0;
      #1;
      total++; if (insts_out_valid !== 2'b01) begin bad++; $display("FAIL fl_refill_valid got=%b exp=01", insts_out_valid); end
      total++; if (insts_out[0].pc !== 32'h50) begin bad++; $display("FAIL fl_refill_pc got=%h exp=50", insts_out[0].pc); end
      insts_out_ready = 1'b1;
      step();
      insts_out_ready = 1'b0;
      #1;
   endtask

   task automatic test_back_to_back();
      insts_in_valid = 1'b1;
      insts_in[0] = mk(32'h20, 32'h4000);
      step();
      insts_in_valid = 1'b0;
      #1;
      total++; if (insts_out_valid !== 2'b01) begin bad++; $display("FAIL b2b_pre_valid got=%b exp=01", insts_out_valid); end
      total++; if (insts_out[0].pc !== 32'h20) begin bad++; $display("FAIL b2b_pre_pc got=%h exp=20", insts_out[0].pc); end
      insts_in_valid = 1'b1;
      insts_in[0] = mk(32'h24, 32'h4001);
      insts_out_ready = 1'b1;
      step();
      insts_in_valid = 1'b0;
      insts_out_ready = 1'b0;
      #1;
      total++; if (insts_out_valid !== 2'b01) begin bad++; $display("FAIL b2b_valid got=%b exp=01", insts_out_valid); end
      total++; if (insts_out[0].pc !== 32'h24) begin bad++; $display("FAIL b2b_pc got=%h exp=24", insts_out[0].pc); end
      insts_out_ready = 1'b1;
      step();
      insts_out_ready = 1'b0;
      #1;
      total++; if (insts_out_valid !== 2'b00) begin bad++; $display("FAIL b2b_drain got=%b exp=00", insts_out_valid); end
   endtask

   task automatic test_stream();
      logic [31:0] q[$];
      int nxt;
      int stall_cyc;
      logic in_v, rdy, exp_stall;
      logic [1:0] exp_v;
      logic [31:0] pc;
      int n;
      nxt = 0;
      stall_cyc = 0;
      reset = 1'b1; insts_in_valid = 1'b0; insts_out_ready = 1'b0; flush = 1'b0;
      step(); step();
      reset = 1'b0;
      for (int cyc = 0; cyc < 300 && (nxt < 10 || q.size() > 0); cyc++) begin
         in_v = (nxt < 10);
         pc = 32'h100 + 32'(4 * nxt);
         rdy = ($urandom_range(0, 2) == 0);
         insts_in_valid = in_v;
         insts_in[0] = mk(pc, pc ^ 32'hA5A5_0000);
         insts_out_ready = rdy;
         #1;
         exp_stall = (DEPTH - q.size()) < FETCH_WIDTH;
         exp_v = {q.size() >= 2, q.size() >= 1};
         total++; if (stall !== exp_stall) begin bad++; $display("FAIL st_stall cyc=%0d got=%b exp=%b", cyc, stall, exp_stall); end
         total++; if (insts_out_valid !== exp_v) begin bad++; $display("FAIL st_valid cyc=%0d got=%b exp=%b", cyc, insts_out_valid, exp_v); end
         for (int i = 0; i < OUTW; i++) begin
            if (i < q.size()) begin
               total++; if (insts_out[i].pc !== q[i]) begin bad++; $display("FAIL st_pc cyc=%0d slot=%0d got=%h exp=%h", cyc, i, insts_out[i].pc, q[i]); end
               total++; if (insts_out[i].inst !== (q[i] ^ 32'hA5A5_0000)) begin bad++; $display("FAIL st_inst cyc=%0d slot=%0d got=%h exp=%h", cyc, i, insts_out[i].inst, q[i] ^ 32'hA5A5_0000); end
            end
         end
         if (exp_stall) stall_cyc++;
         step();
         if (rdy) begin
            n = (q.size() < OUTW) ? q.size() : OUTW;
            for (int j = 0; j < n; j++) void'(q.pop_front());
         end
         if (in_v && !exp_stall) begin
            q.push_back(pc);
            nxt++;
         end
      end
      insts_in_valid = 1'b0;
      insts_out_ready = 1'b0;
      #1;
      total++; if (nxt != 10 || q.size() != 0) begin bad++; $display("FAIL st_timeout got=%0d/%0d exp=10/0", nxt, q.size()); end
      total++; if (insts_out_valid !== 2'b00) begin bad++; $display("FAIL st_end_valid got=%b exp=00", insts_out_valid); end
`ifdef INST_BUFFER_PERF_EN
      total++; if (perf_stall_cycles !== 32'(stall_cyc)) begin bad++; $display("FAIL st_perf_stall got=%0d exp=%0d", perf_stall_cycles, stall_cyc); end
      total++; if (perf_flush_count !== 32'd0) begin bad++; $display("FAIL st_perf_flush got=%0d exp=0", perf_flush_count); end
`endif
   endtask

   initial begin
      test_reset();
      test_push_pop();
      test_full();
      test_flush();
      test_back_to_back();
      test_stream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
